// File: rtl/floo_vc_pkg.sv
// Shared VC definitions: default link types, vc_id field geometry, credit typedef,
// and the binary-to-onehot helper used by ports and allocators.
package floo_vc_pkg;

  localparam int unsigned VcIdFieldW = 2;
  localparam int unsigned MaxNumVC   = 16;
  localparam int unsigned DefVCDepth = 3;

  typedef logic [$clog2(DefVCDepth+1)-1:0] credit_t;

  // vc_id leads the header so its position is fixed regardless of the other fields
  typedef struct packed {
    logic [VcIdFieldW-1:0] vc_id;
    logic [3:0]            dst;
    logic [1:0]            src;
  } hdr_t;

  typedef struct packed {
    hdr_t        hdr;
    logic [23:0] payload;
  } flit_t;

  // Bit position of the header's LSB inside a flit whose header sits at the MSBs
  function automatic int unsigned hdr_lsb(input int unsigned flit_w, input int unsigned hdr_w);
    return flit_w - hdr_w;
  endfunction

  // Ids outside the table produce an all-zero vector
  function automatic logic [MaxNumVC-1:0] vc_id_to_oh(input int unsigned id);
    logic [MaxNumVC-1:0] oh;
    oh = '0;
    if (id < MaxNumVC) oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/floo_vc_credit_counter.sv
// One downstream-VC credit counter with saturation and per-cycle error pulses.
module floo_vc_credit_counter #(
  parameter int unsigned VCDepth     = 3,
  parameter int unsigned CreditWidth = $clog2(VCDepth+1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   inc_i,
  input  logic                   dec_i,
  output logic [CreditWidth-1:0] cnt_o,
  output logic                   avail_o,
  output logic                   underflow_o,
  output logic                   overflow_o
);

  localparam logic [CreditWidth-1:0] Full = CreditWidth'(VCDepth);

  logic [CreditWidth-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    overflow_o  = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == Full) overflow_o = 1'b1;
      else               cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) underflow_o = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= Full;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign avail_o = (cnt_q != '0);

endmodule

// File: rtl/floo_vc_output_port.sv
// VC router output stage: per-VC downstream credit tracking, sticky protocol
// error flags and a one-cycle link register that stamps the chosen VC into the header.
module floo_vc_output_port
  import floo_vc_pkg::*;
#(
  parameter type         hdr_t       = floo_vc_pkg::hdr_t,
  parameter type         flit_t      = floo_vc_pkg::flit_t,
  parameter int unsigned NumVC       = 4,
  parameter int unsigned NumVCWidth  = 2,
  parameter int unsigned VCDepth     = 3,
  parameter int unsigned CreditWidth = $clog2(VCDepth+1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         credit_v_i,
  input  logic [NumVCWidth-1:0]        credit_id_i,
  output logic [NumVC-1:0]             vc_credit_avail_o,
  output logic [NumVC*CreditWidth-1:0] vc_credit_cnt_o,
  input  logic                         send_v_i,
  input  logic [NumVCWidth-1:0]        send_vc_id_i,
  input  flit_t                        send_flit_i,
  output logic                         data_v_o,
  output flit_t                        data_o,
  output logic                         err_underflow_o,
  output logic                         err_overflow_o
);

  localparam int unsigned HdrLsb = hdr_lsb($bits(flit_t), $bits(hdr_t));

  logic [NumVC-1:0] credit_oh, send_oh, uf, of;
  logic             credit_oor, send_oor;

  assign credit_oh  = NumVC'(vc_id_to_oh(32'(credit_id_i)));
  assign send_oh    = NumVC'(vc_id_to_oh(32'(send_vc_id_i)));
  assign credit_oor = credit_v_i && (32'(credit_id_i) >= NumVC);
  assign send_oor   = send_v_i && (32'(send_vc_id_i) >= NumVC);

  for (genvar v = 0; v < NumVC; v++) begin : g_vc
    floo_vc_credit_counter #(
      .VCDepth    (VCDepth),
      .CreditWidth(CreditWidth)
    ) i_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (credit_v_i && credit_oh[v]),
      .dec_i      (send_v_i && send_oh[v]),
      .cnt_o      (vc_credit_cnt_o[v*CreditWidth +: CreditWidth]),
      .avail_o    (vc_credit_avail_o[v]),
      .underflow_o(uf[v]),
      .overflow_o (of[v])
    );
  end

  logic  err_uf_q, err_of_q, data_v_q;
  flit_t data_d, data_q;
  hdr_t  hdr;

  always_comb begin
    data_d       = send_flit_i;
    hdr          = hdr_t'(send_flit_i[HdrLsb +: $bits(hdr_t)]);
    hdr.vc_id    = VcIdFieldW'(send_vc_id_i);
    data_d[HdrLsb +: $bits(hdr_t)] = hdr;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_v_q <= 1'b0;
      data_q   <= '0;
      err_uf_q <= 1'b0;
      err_of_q <= 1'b0;
    end else begin
      data_v_q <= send_v_i;
      if (send_v_i) data_q <= data_d;
      err_uf_q <= err_uf_q | (|uf) | send_oor;
      err_of_q <= err_of_q | (|of) | credit_oor;
    end
  end

  assign data_v_o        = data_v_q;
  assign data_o          = data_q;
  assign err_underflow_o = err_uf_q;
  assign err_overflow_o  = err_of_q;

endmodule

// File: doc/floo_vc_output_port.md
Name: floo_vc_output_port

Overview:
- Output stage of a VC router, directly upstream of the neighbouring router's VC input port.
- Tracks per-VC credits for the downstream input buffers and tells switch allocation which VCs may send.
- Registers each granted flit from switch traversal onto the link, writing the chosen VC into its header.
- Consumes the credit-return pulses (one valid bit plus a binary VC id) that the downstream input port emits when it pops a flit.

Parameters:
- flit_t, logic: link flit type, header first; the header has field vc_id.
- hdr_t, logic: header type.
- NumVC, 4: number of virtual channels.
- NumVCWidth, 2: width of a VC id; must be at least $clog2(NumVC).
- VCDepth, 3: downstream per-VC buffer depth, which is also the initial credit count.
- CreditWidth, $clog2(VCDepth+1): credit counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset (asynchronous, active-high)
- credit_v_i  in  1  credit return valid from downstream
- credit_id_i  in  NumVCWidth  VC being credited
- vc_credit_avail_o  out  NumVC  per-VC "counter > 0", for switch allocation
- vc_credit_cnt_o  out  NumVC*CreditWidth  raw counters, for debug and arbitration weighting
- send_v_i  in  1  switch traversal grants a flit this cycle
- send_vc_id_i  in  NumVCWidth  downstream VC the flit is sent on
- send_flit_i  in  $bits(flit_t)  flit to transmit
- data_v_o  out  1  link flit valid
- data_o  out  $bits(flit_t)  link flit
- err_underflow_o  out  1  sticky: send with zero credit
- err_overflow_o  out  1  sticky: credit with full counter

Behaviour:
- Reset (asynchronous, rst_i=1):
  - every counter = VCDepth; vc_credit_avail_o = all ones.
  - data_v_o = 0; data_o = 0.
  - both error flags = 0.
  - Reset asserted mid-operation discards the in-flight link register and restores full credit.
- Counters: one per VC, CreditWidth bits, updated on the clock edge.
  - inc = credit_v_i && credit_id_i == v
  - dec = send_v_i && send_vc_id_i == v
  - inc only: +1; dec only: -1; inc and dec on the same VC in the same cycle: unchanged.
  - Events on different VCs update independently.
- Underflow: dec while the counter is 0 and no inc on that VC.
  - The counter stays 0 and err_underflow_o sets.
  - The flit is still transmitted; the bench treats this as a protocol violation.
- Overflow: inc while the counter equals VCDepth and no dec on that VC.
  - The counter stays at VCDepth and err_overflow_o sets.
- The error flags are sticky until reset.
- Out-of-range ids (id >= NumVC) are ignored for counting, and the matching error flag sets.
- Credit availability:
  - vc_credit_avail_o[v] = (counter[v] != 0), driven purely from the registered count.
  - There is no same-cycle bypass: a credit arriving in cycle t makes that VC available in cycle t+1.
- Link register (latency 1):
  - On send_v_i=1, next cycle data_v_o=1 and data_o = send_flit_i with hdr.vc_id replaced by send_vc_id_i, zero-extended to the field width.
  - On send_v_i=0, next cycle data_v_o=0 and data_o holds its previous value.
- Back-to-back sends on any VC are accepted every cycle; there is no ready signal because credits are the only flow control.
- Credit return is fire-and-forget: credit_v_i is a single-cycle pulse and every pulse is counted.

Decomposition:
- Shared package floo_vc_pkg:
  - the vc_id field position and width helpers;
  - a typedef for a credit counter sized from VCDepth;
  - function vc_id_to_oh for the binary-to-onehot conversion, reused by the input port and allocators.
- Sub-module floo_vc_credit_counter holds one counter with its inc/dec/saturation and error outputs, and is instantiated NumVC times.
- The link register and header rewrite stay in the top module.

Test Plan:
- Reset release, idle 5 cycles -> all counters 3, avail=4'b1111, data_v_o=0, no errors.
- 3 sends on VC1 in consecutive cycles -> data_v_o high for 3 cycles, one cycle after each send, with hdr.vc_id=1; cnt[1]=0 and avail=4'b1101 after the third edge.
- With cnt[2]=1: send VC2 and credit VC2 in the same cycle -> cnt[2] stays 1 and avail[2] stays 1; then credit VC0 while cnt[0]=3 -> cnt[0]=3 and err_overflow_o=1, sticky.
- With cnt[3]=0: send VC3 -> data_v_o=1 next cycle, cnt[3]=0, err_underflow_o=1; a credit on VC3 the next cycle -> avail[3] rises one cycle later.
- Random sends gated by avail, plus random credits delayed 2-6 cycles, 10k cycles -> counters always in [0,3], no error flags, and every counter returns to 3 once idle.
- Assert rst_i mid-burst, with cnt=(0,2,1,3) and data_v_o=1 -> all outputs go immediately (asynchronously) to reset values; after release the counters read 3.
